mux8_rr_arbiter: RTL

//   Round-robin scheduler sharing the 8:1 bit multiplexer among 8 requesters.

---
 rtl/mux8_rr_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// mux8_rr_arbiter: round-robin owner of a shared 8:1 bit mux, streaming the
// granted requester's bit with valid/ready and bursts capped at MAX_BURST beats.
// Rev 1.0
module mux8_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] a,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       y,
  output logic       busy
);

  localparam logic [0:0]       ST_IDLE     = 1'b0;
  localparam logic [0:0]       ST_GRANT    = 1'b1;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [0:0]       state_q, state_d;
  logic [7:0]       gnt_q,   gnt_d;
  logic [2:0]       sel_q,   sel_d;
  logic [2:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic       beat;
  logic       grant_end;
  logic [2:0] next_ptr;

  // First requester at or after 'start', wrapping modulo 8.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    pick = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign busy      = (state_q == ST_GRANT);
  assign out_valid = busy && req[sel_q];
  assign beat      = out_valid && out_ready;
  assign grant_end = busy && (!req[sel_q] || (beat && (cnt_q == C_LAST_BEAT)));
  assign next_ptr  = sel_q + 3'd1;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign y         = a[sel_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d = ST_GRANT;
        sel_d   = pick(req, ptr_q);
        gnt_d   = 8'd1 << sel_d;
        cnt_d   = '0;
      end
    end else if (grant_end) begin
      // Handoff happens on the same edge so the stream sees no bubble.
      ptr_d = next_ptr;
      cnt_d = '0;
      if (|req) begin
        sel_d = pick(req, next_ptr);
        gnt_d = 8'd1 << sel_d;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end else if (beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire
